// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the control sequencer: state codes, opcodes, bus sources
// and the packed strobe bundle handed from the decoder to the top.
package cpu_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b11111,
    ST_FETCH  = 5'b10000,
    ST_DECODE = 5'b00000,
    ST_LOAD   = 5'b00001,
    ST_MOV    = 5'b00010,
    ST_ALU1   = 5'b00011,
    ST_ALU2   = 5'b00100,
    ST_ALU3   = 5'b00101,
    ST_BR     = 5'b00110
  } state_e;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_BR   = 3'd6;
  localparam logic [2:0] OP_NOP  = 3'd7;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_DIN  = 2'b01;
  localparam logic [1:0] BUS_REG  = 2'b10;
  localparam logic [1:0] BUS_G    = 2'b11;

  typedef struct packed {
    logic [1:0] bus_sel;
    logic [2:0] reg_sel;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic [1:0] alu_op;
    logic       pc_inc;
    logic       pc_load;
    logic       done;
  } strobe_t;

  function automatic logic legal_state(input logic [4:0] s);
    case (s)
      ST_IDLE, ST_FETCH, ST_DECODE, ST_LOAD, ST_MOV,
      ST_ALU1, ST_ALU2, ST_ALU3, ST_BR: legal_state = 1'b1;
      default:                          legal_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Pure combinational decode of current state + IR fields into datapath strobes.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [2:0] code,
  input  logic [2:0] rx,
  input  logic [2:0] ry,
  output strobe_t    stb
);

  logic [7:0] rx_oh;
  logic [2:0] alu_sel;

  assign rx_oh   = 8'd1 << rx;
  // ALU opcodes start at 2, so the ALU function select is the opcode rebased to 0
  assign alu_sel = code - OP_ADD;

  always_comb begin
    stb = '0;
    case (state)
      ST_FETCH: begin
        stb.bus_sel = BUS_DIN;
        stb.pc_inc  = 1'b1;
      end
      ST_LOAD: begin
        stb.bus_sel = BUS_DIN;
        stb.r_in    = rx_oh;
        stb.done    = 1'b1;
      end
      ST_MOV: begin
        stb.bus_sel = BUS_REG;
        stb.reg_sel = ry;
        stb.r_in    = rx_oh;
        stb.done    = 1'b1;
      end
      ST_ALU1: begin
        stb.bus_sel = BUS_REG;
        stb.reg_sel = rx;
        stb.a_in    = 1'b1;
      end
      ST_ALU2: begin
        stb.bus_sel = BUS_REG;
        stb.reg_sel = ry;
        stb.g_in    = 1'b1;
        stb.alu_op  = alu_sel[1:0];
      end
      ST_ALU3: begin
        stb.bus_sel = BUS_G;
        stb.r_in    = rx_oh;
        stb.done    = 1'b1;
      end
      ST_BR: begin
        stb.bus_sel = BUS_REG;
        stb.reg_sel = ry;
        stb.pc_load = 1'b1;
        stb.done    = 1'b1;
      end
      default: stb = '0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Control sequencer: registers the state chosen by find_ns, holds the IR, counts
// retired instructions and flags illegal next-state codes.
module cpu_ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int IW    = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       next_state,
  input  logic [IW-1:0]    din,
  output logic [4:0]       state,
  output logic [2:0]       code,
  output logic [1:0]       bus_sel,
  output logic [2:0]       reg_sel,
  output logic [7:0]       r_in,
  output logic             a_in,
  output logic             g_in,
  output logic [1:0]       alu_op,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             err
);

  state_e        state_q, state_d;
  logic          bad_ns;
  logic [IW-1:0] ir;
  strobe_t       stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir        <= '0;
      instr_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) ir <= din;
      if (stb.done) instr_cnt <= instr_cnt + CNT_W'(1);
      if (bad_ns) err <= 1'b1;
    end
  end

  // An unknown code from find_ns parks the sequencer in IDLE rather than wandering
  always_comb begin
    bad_ns  = !legal_state(next_state);
    state_d = bad_ns ? ST_IDLE : state_e'(next_state);
  end

  cpu_ctrl_decode u_decode (
    .state (state_q),
    .code  (ir[IW-1:IW-3]),
    .rx    (ir[5:3]),
    .ry    (ir[2:0]),
    .stb   (stb)
  );

  assign state   = state_q;
  assign code    = ir[IW-1:IW-3];
  assign bus_sel = stb.bus_sel;
  assign reg_sel = stb.reg_sel;
  assign r_in    = stb.r_in;
  assign a_in    = stb.a_in;
  assign g_in    = stb.g_in;
  assign alu_op  = stb.alu_op;
  assign pc_inc  = stb.pc_inc;
  assign pc_load = stb.pc_load;
  assign done    = stb.done;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: the bench plays find_ns, keeps a behavioural model of the
// sequencer and checks every cycle, plus directed sequences with literal expectations.
module tb_cpu_ctrl_seq;

  localparam logic [4:0] S_IDLE = 5'b11111, S_FETCH = 5'b10000, S_DEC = 5'b00000,
                         S_LOAD = 5'b00001, S_MOV = 5'b00010, S_A1 = 5'b00011,
                         S_A2 = 5'b00100, S_A3 = 5'b00101, S_BR = 5'b00110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  next_state = S_IDLE;
  logic [8:0]  din = '0;
  logic [4:0]  state;
  logic [2:0]  code, reg_sel;
  logic [1:0]  bus_sel, alu_op;
  logic [7:0]  r_in;
  logic        a_in, g_in, pc_inc, pc_load, done, err;
  logic [15:0] instr_cnt;

  cpu_ctrl_seq #(.IW(9), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .next_state(next_state), .din(din),
    .state(state), .code(code), .bus_sel(bus_sel), .reg_sel(reg_sel),
    .r_in(r_in), .a_in(a_in), .g_in(g_in), .alu_op(alu_op),
    .pc_inc(pc_inc), .pc_load(pc_load), .done(done),
    .instr_cnt(instr_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit run_chk = 1'b0;

  // model of the sequencer's visible state
  logic [4:0]  es;
  logic [8:0]  eir;
  logic [15:0] ecnt;
  logic        eerr;

  wire [19:0] act = {bus_sel, reg_sel, r_in, a_in, g_in, alu_op, pc_inc, pc_load, done};

  function automatic bit is_legal(input logic [4:0] s);
    return s inside {S_IDLE, S_FETCH, S_DEC, S_LOAD, S_MOV, S_A1, S_A2, S_A3, S_BR};
  endfunction

  // {bus, reg, r_in, a, g, alu, inc, load, done} required in a given state
  function automatic logic [19:0] exp_stb(input logic [4:0] s, input logic [8:0] ir);
    logic [1:0] bus, alu; logic [2:0] rs; logic [7:0] ri; logic a, g, inc, ld, dn;
    logic [2:0] d;
    bus = 0; alu = 0; rs = 0; ri = 0; a = 0; g = 0; inc = 0; ld = 0; dn = 0;
    d = ir[8:6] - 3'd2;
    case (s)
      S_FETCH: begin bus = 1; inc = 1; end
      S_LOAD:  begin bus = 1; ri = 8'd1 << ir[5:3]; dn = 1; end
      S_MOV:   begin bus = 2; rs = ir[2:0]; ri = 8'd1 << ir[5:3]; dn = 1; end
      S_A1:    begin bus = 2; rs = ir[5:3]; a = 1; end
      S_A2:    begin bus = 2; rs = ir[2:0]; g = 1; alu = d[1:0]; end
      S_A3:    begin bus = 3; ri = 8'd1 << ir[5:3]; dn = 1; end
      S_BR:    begin bus = 2; rs = ir[2:0]; ld = 1; dn = 1; end
      default: ;
    endcase
    return {bus, rs, ri, a, g, alu, inc, ld, dn};
  endfunction

  // what a well-behaved find_ns would present
  function automatic logic [4:0] find_ns(input logic [4:0] s, input logic [8:0] ir);
    case (s)
      S_IDLE:  return S_FETCH;
      S_FETCH: return S_DEC;
      S_DEC:   case (ir[8:6])
                 3'd0: return S_LOAD;
                 3'd1: return S_MOV;
                 3'd6: return S_BR;
                 3'd7: return S_FETCH;
                 default: return S_A1;
               endcase
      S_A1:    return S_A2;
      S_A2:    return S_A3;
      default: return S_FETCH;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("m_state", 32'(state), 32'(es));
      chk("m_strobes", 32'(act), 32'(exp_stb(es, eir)));
      chk("m_code", 32'(code), 32'(eir[8:6]));
      chk("m_cnt", 32'(instr_cnt), 32'(ecnt));
      chk("m_err", 32'(err), 32'(eerr));
      chk("m_onehot", 32'($countones(r_in) <= 1), 32'd1);
    end
  end

  // apply inputs, step the model across one rising edge, return at the falling edge
  task automatic drive(input bit r, input logic [4:0] ns, input logic [8:0] d);
    logic [19:0] s;
    rst = r; next_state = ns; din = d;
    @(posedge clk);
    if (r) begin
      es = S_IDLE; eir = '0; ecnt = '0; eerr = 1'b0;
    end else begin
      s = exp_stb(es, eir);
      if (s[0]) ecnt = ecnt + 16'd1;
      if (es == S_FETCH) eir = d;
      if (is_legal(ns)) es = ns;
      else begin es = S_IDLE; eerr = 1'b1; end
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    drive(1, S_IDLE, '0);
    drive(1, S_IDLE, '0);
    run_chk = 1'b1;
    chk("rst_state", 32'(state), 32'h1F);
    chk("rst_strobes", 32'(act), 32'h0);
    chk("rst_cnt", 32'(instr_cnt), 32'h0);

    // LOAD R3
    drive(0, S_FETCH, '0);
    chk("fetch_pcinc", 32'(pc_inc), 32'd1);
    chk("fetch_bus", 32'(bus_sel), 32'd1);
    drive(0, S_DEC, 9'b000_011_000);
    chk("load_code", 32'(code), 32'd0);
    drive(0, S_LOAD, '0);
    chk("load_rin", 32'(r_in), 32'h08);
    chk("load_bus", 32'(bus_sel), 32'd1);
    chk("load_done", 32'(done), 32'd1);
    drive(0, S_FETCH, '0);
    chk("load_cnt", 32'(instr_cnt), 32'd1);
    chk("load_done_once", 32'(done), 32'd0);

    // XOR R1,R2
    drive(0, S_DEC, 9'b011_001_010);
    drive(0, S_A1, '0);
    chk("alu1_reg", 32'(reg_sel), 32'd1);
    chk("alu1_ain", 32'(a_in), 32'd1);
    drive(0, S_A2, '0);
    chk("alu2_reg", 32'(reg_sel), 32'd2);
    chk("alu2_op", 32'(alu_op), 32'd1);
    chk("alu2_gin", 32'(g_in), 32'd1);
    drive(0, S_A3, '0);
    chk("alu3_bus", 32'(bus_sel), 32'd3);
    chk("alu3_rin", 32'(r_in), 32'h02);
    chk("alu3_done", 32'(done), 32'd1);
    drive(0, S_FETCH, '0);
    chk("xor_cnt", 32'(instr_cnt), 32'd2);

    // reset held two cycles in the middle of ALU2
    drive(0, S_DEC, 9'b011_001_010);
    drive(0, S_A1, '0);
    drive(0, S_A2, '0);
    drive(1, S_A3, '0);
    drive(1, S_A3, '0);
    chk("abort_state", 32'(state), 32'h1F);
    chk("abort_strobes", 32'(act), 32'h0);
    chk("abort_cnt", 32'(instr_cnt), 32'd0);
    chk("abort_err", 32'(err), 32'd0);

    // BR R5
    drive(0, S_FETCH, '0);
    drive(0, S_DEC, 9'b110_000_101);
    drive(0, S_BR, '0);
    chk("br_reg", 32'(reg_sel), 32'd5);
    chk("br_load", 32'(pc_load), 32'd1);
    chk("br_done", 32'(done), 32'd1);
    drive(0, S_FETCH, '0);
    chk("br_next", 32'(state), 32'h10);
    chk("br_cnt", 32'(instr_cnt), 32'd1);

    // NOP: back to FETCH with no retirement
    drive(0, S_DEC, 9'b111_010_001);
    chk("nop_code", 32'(code), 32'd7);
    drive(0, S_FETCH, '0);
    chk("nop_cnt", 32'(instr_cnt), 32'd1);

    // illegal next_state: sticky err until reset
    drive(0, 5'b01010, '0);
    chk("ill_state", 32'(state), 32'h1F);
    chk("ill_err", 32'(err), 32'd1);
    drive(0, S_FETCH, '0);
    drive(0, S_DEC, 9'b001_000_001);
    chk("ill_sticky", 32'(err), 32'd1);
    drive(1, S_IDLE, '0);
    chk("ill_clear", 32'(err), 32'd0);

    // randomized traffic: mostly well-formed sequences, some illegal codes and resets
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] ns;
      bit r;
      r  = ($urandom % 100) == 0;
      ns = (($urandom % 40) == 0) ? 5'($urandom) : find_ns(es, eir);
      drive(r, ns, 9'($urandom));
    end

    // counter wrap: sit in MOV so every edge retires one instruction
    drive(1, S_IDLE, '0);
    drive(0, S_FETCH, '0);
    drive(0, S_DEC, 9'b001_000_001);
    for (int i = 0; i < 65536; i++) drive(0, S_MOV, '0);
    chk("wrap_max", 32'(instr_cnt), 32'hFFFF);
    drive(0, S_FETCH, '0);
    chk("wrap_zero", 32'(instr_cnt), 32'd0);

    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
